// File: rtl/ram_port_adapter_pkg.sv
// Shared widths and request bundle for the RAM port adapter.
// Defaults match the 14b x 64 dual-port RAM.
package ram_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 14;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } ram_req_t;

endpackage

// File: rtl/ram_port_adapter_if.sv
// Request/response handshake plus RAM port wiring.
// slave = adapter side, master = requester/RAM side.
interface ram_port_adapter_if
  import ram_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;

  logic [AW-1:0] mem_addr;
  logic          mem_write_en;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_data,
    input  rsp_ready,
    output mem_addr, mem_write_en, mem_data_in,
    input  mem_data_out
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_data,
    output rsp_ready,
    input  mem_addr, mem_write_en, mem_data_in,
    output mem_data_out
  );

endinterface

// File: rtl/ram_port_adapter_sync_fifo.sv
// Response buffer: power-of-2 ring with occupancy count.
// Push and pop in the same cycle are both honoured.
module sync_fifo #(
  parameter int W     = 14,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + AW'(1);
    if (pop_i)  rptr_d = rptr_q + AW'(1);
    if (push_i && !pop_i)      count_d = count_q + CW'(1);
    else if (!push_i && pop_i) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  // Credits bound in-flight + stored reads, so a full push is a design bug.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_i && count_q == CW'(DEPTH)))
        else $error("sync_fifo push while full");
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ram_port_adapter.sv
// Valid/ready front end for one RAM port: credit counter,
// read-latency tag pipe and in-order response FIFO.
module ram_port_adapter
  import ram_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int RSP_DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  ram_port_adapter_if.slave  bus,
  output logic               busy
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW-1:0] MAX_OUT = CW'(RSP_DEPTH);

  ram_req_t                req;
  logic [CW-1:0]           out_q, out_d;
  logic [READ_LATENCY-1:0] tag_q, tag_d;
  logic [CW-1:0]           fifo_cnt;
  logic                    acc;
  logic                    rd_acc;
  logic                    pop;
  logic                    push;

  assign req = '{we:    bus.req_we,
                 addr:  bus.req_addr,
                 wdata: bus.req_wdata};

  assign bus.req_ready = !rst && (out_q < MAX_OUT);
  assign acc           = bus.req_valid && bus.req_ready;
  assign rd_acc        = acc && !req.we;

  assign bus.mem_addr     = req.addr;
  assign bus.mem_data_in  = req.wdata;
  assign bus.mem_write_en = acc && req.we;

  assign bus.rsp_valid = !rst && (fifo_cnt != '0);
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign push          = tag_q[READ_LATENCY-1];
  assign busy          = !rst && (out_q != '0);

  always_comb begin
    out_d = out_q;
    if (rd_acc && !pop)      out_d = out_q + CW'(1);
    else if (!rd_acc && pop) out_d = out_q - CW'(1);
    // Tag reaches the last stage exactly when mem_data_out is valid.
    tag_d    = tag_q << 1;
    tag_d[0] = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      tag_q <= '0;
    end else begin
      out_q <= out_d;
      tag_q <= tag_d;
    end
  end

  sync_fifo #(
    .W     (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (bus.mem_data_out),
    .pop_i   (pop),
    .rdata_o (bus.rsp_data),
    .count_o (fifo_cnt)
  );

endmodule
